tpu_mac_pipe: RTL and testbench

//  Next-generation systolic multiply-accumulate cell for the TPU array. Two-stage

---
 rtl/tpu_mac_pipe.sv | 112 +++++++++++
 tb/tb_tpu_mac_pipe.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_mac_pipe.sv
// Systolic multiply-accumulate cell: registered multiply, then accumulate with
// signed/unsigned operation, optional saturation, sticky overflow and a valid handshake.
module tpu_mac_pipe #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter bit SAT_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic               clr,
    input  logic               WrEn,
    input  logic               sgn,
    input  logic [BITS_AB-1:0] Ain,
    input  logic [BITS_AB-1:0] Bin,
    input  logic [BITS_C-1:0]  Cin,
    output logic [BITS_AB-1:0] Aout,
    output logic [BITS_AB-1:0] Bout,
    output logic [BITS_C-1:0]  Cout,
    output logic               out_valid,
    output logic               ovf
);
    localparam int PW = 2 * BITS_AB;

    generate
        if (BITS_C < PW) begin : g_bad_width
            $error("tpu_mac_pipe: BITS_C must be at least 2*BITS_AB");
        end
    endgenerate

    logic [BITS_AB-1:0] r_aout, r_bout;
    logic [PW-1:0]      r_p1;
    logic               r_v1, r_clr1, r_wren1, r_sgn1;
    logic [BITS_C-1:0]  r_cin1;
    logic [BITS_C-1:0]  r_acc;
    logic               r_out_valid, r_ovf;

    logic [PW-1:0]      w_a_ext, w_b_ext, w_prod;
    logic [BITS_C:0]    w_acc_ext, w_p_ext, w_sum;
    logic               w_ovf;
    logic [BITS_C-1:0]  w_sat, w_next_acc;

    // Extending both operands to the full product width before multiplying gives
    // the correct low 2*BITS_AB bits for signed and unsigned alike.
    always_comb begin
        w_a_ext = sgn ? {{BITS_AB{Ain[BITS_AB-1]}}, Ain} : {{BITS_AB{1'b0}}, Ain};
        w_b_ext = sgn ? {{BITS_AB{Bin[BITS_AB-1]}}, Bin} : {{BITS_AB{1'b0}}, Bin};
        w_prod  = w_a_ext * w_b_ext;
    end

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_acc_ext  = r_sgn1 ? {r_acc[BITS_C-1], r_acc} : {1'b0, r_acc};
        w_p_ext    = r_sgn1 ? {{(BITS_C+1-PW){r_p1[PW-1]}}, r_p1}
                            : {{(BITS_C+1-PW){1'b0}}, r_p1};
        w_sum      = w_acc_ext + w_p_ext;
        w_ovf      = r_sgn1 ? (w_sum[BITS_C] ^ w_sum[BITS_C-1]) : w_sum[BITS_C];
        w_sat      = {BITS_C{1'b1}};
        if (r_sgn1) begin
            // True sign of the wide sum picks which bound was crossed.
            w_sat = w_sum[BITS_C] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
        end
        w_next_acc = (w_ovf && SAT_EN) ? w_sat : w_sum[BITS_C-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aout      <= '0;
            r_bout      <= '0;
            r_p1        <= '0;
            r_v1        <= 1'b0;
            r_clr1      <= 1'b0;
            r_wren1     <= 1'b0;
            r_sgn1      <= 1'b0;
            r_cin1      <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= en & r_v1;
            if (en) begin
                r_aout  <= Ain;
                r_bout  <= Bin;
                r_p1    <= w_prod;
                r_v1    <= in_valid;
                r_clr1  <= clr;
                r_wren1 <= WrEn;
                r_sgn1  <= sgn;
                r_cin1  <= Cin;
                if (r_v1) begin
                    if (r_clr1) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end else if (r_wren1) begin
                        r_acc <= r_cin1;
                    end else begin
                        r_acc <= w_next_acc;
                        if (w_ovf) r_ovf <= 1'b1;
                    end
                end
            end
        end
    end

    assign Aout      = r_aout;
    assign Bout      = r_bout;
    assign Cout      = r_acc;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_tpu_mac_pipe.sv
// Self-checking bench for tpu_mac_pipe: a saturating and a wrapping instance share
// stimulus and are compared against an integer-arithmetic reference model.
module tb_tpu_mac_pipe;
    logic        clk = 1'b0;
    logic        rst, en, in_valid, clr, wren, sgn;
    logic [7:0]  ain, bin;
    logic [15:0] cin;
    logic [7:0]  aout_s, bout_s, aout_w, bout_w;
    logic [15:0] cout_s, cout_w;
    logic        ov_s, ov_w, ovf_s, ovf_w;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [15:0] c_sat;
        logic        o_sat;
        logic [15:0] c_wrap;
        logic        o_wrap;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_acc[2];
    bit          m_ovf[2];
    bit          m_v1, m_ov;
    logic [7:0]  exp_aout, exp_bout;

    tpu_mac_pipe #(.BITS_AB(8), .BITS_C(16), .SAT_EN(1'b1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .clr(clr), .WrEn(wren),
        .sgn(sgn), .Ain(ain), .Bin(bin), .Cin(cin), .Aout(aout_s), .Bout(bout_s),
        .Cout(cout_s), .out_valid(ov_s), .ovf(ovf_s));

    tpu_mac_pipe #(.BITS_AB(8), .BITS_C(16), .SAT_EN(1'b0)) dut_w (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .clr(clr), .WrEn(wren),
        .sgn(sgn), .Ain(ain), .Bin(bin), .Cin(cin), .Aout(aout_w), .Bout(bout_w),
        .Cout(cout_w), .out_valid(ov_w), .ovf(ovf_w));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: index 0 saturates, index 1 wraps; values judged as plain integers.
    task automatic model_op(input logic c, input logic w, input logic s,
                            input logic [7:0] a, input logic [7:0] b, input logic [15:0] ci);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            longint prod, accv, sum, lo, hi;
            if (c) begin
                m_acc[k] = 16'd0;
                m_ovf[k] = 1'b0;
            end else if (w) begin
                m_acc[k] = ci;
            end else begin
                prod = s ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
                accv = s ? longint'($signed(m_acc[k])) : longint'(m_acc[k]);
                sum  = accv + prod;
                lo   = s ? -32768 : 0;
                hi   = s ? 32767 : 65535;
                if (sum > hi || sum < lo) begin
                    m_ovf[k] = 1'b1;
                    if (k == 0) sum = (sum > hi) ? hi : lo;
                end
                m_acc[k] = 16'(sum);
            end
        end
        e.c_sat  = m_acc[0];
        e.o_sat  = m_ovf[0];
        e.c_wrap = m_acc[1];
        e.o_wrap = m_ovf[1];
        exp_q.push_back(e);
    endtask

    task automatic reset_model();
        exp_q.delete();
        m_acc[0] = 16'd0; m_acc[1] = 16'd0;
        m_ovf[0] = 1'b0;  m_ovf[1] = 1'b0;
        m_v1 = 1'b0; m_ov = 1'b0;
        exp_aout = 8'd0; exp_bout = 8'd0;
    endtask

    task automatic drive(input logic v, input logic c, input logic w, input logic s,
                         input logic [7:0] a, input logic [7:0] b, input logic [15:0] ci);
        en = 1'b1; in_valid = v; clr = c; wren = w; sgn = s; ain = a; bin = b; cin = ci;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
    endtask

    // One clock: update the model for what the edge accepts, then check outputs #1 after it.
    task automatic cycle();
        exp_t e;
        if (en) begin
            m_ov = m_v1;
            m_v1 = in_valid;
            exp_aout = ain;
            exp_bout = bin;
            if (in_valid) model_op(clr, wren, sgn, ain, bin, cin);
        end else begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (ov_s !== m_ov || ov_w !== m_ov) begin
            tests_failed++;
            $display("FAIL out_valid: got sat=%b wrap=%b expected %b", ov_s, ov_w, m_ov);
        end
        tests_run++;
        if (aout_s !== exp_aout || bout_s !== exp_bout || aout_w !== exp_aout || bout_w !== exp_bout) begin
            tests_failed++;
            $display("FAIL forward: got Aout=%h Bout=%h expected %h %h", aout_s, bout_s, exp_aout, exp_bout);
        end
        if (m_ov) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL result: out_valid with no op expected");
            end else begin
                e = exp_q.pop_front();
                if (cout_s !== e.c_sat || ovf_s !== e.o_sat || cout_w !== e.c_wrap || ovf_w !== e.o_wrap) begin
                    tests_failed++;
                    $display("FAIL result: got sat=%h/%b wrap=%h/%b expected sat=%h/%b wrap=%h/%b",
                             cout_s, ovf_s, cout_w, ovf_w, e.c_sat, e.o_sat, e.c_wrap, e.o_wrap);
                end
            end
        end
    endtask

    task automatic check_zero(input string name);
        tests_run++;
        if (aout_s !== 8'd0 || bout_s !== 8'd0 || cout_s !== 16'd0 || ov_s !== 1'b0 || ovf_s !== 1'b0 ||
            aout_w !== 8'd0 || bout_w !== 8'd0 || cout_w !== 16'd0 || ov_w !== 1'b0 || ovf_w !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: got Aout=%h Bout=%h Cout=%h/%h ov=%b ovf=%b expected all zero",
                     name, aout_s, bout_s, cout_s, cout_w, ov_s, ovf_s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        reset_model();
        #1;
        check_zero("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_mac();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 16'd100);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 8'hFC, 16'd0);
        cycle();
        tests_run++;
        if (cout_s !== 16'd100 || ov_s !== 1'b1 || aout_s !== 8'd3 || bout_s !== 8'hFC) begin
            tests_failed++;
            $display("FAIL load: got Cout=%0d ov=%b Aout=%h Bout=%h expected 100 1 03 fc",
                     cout_s, ov_s, aout_s, bout_s);
        end
        idle();
        cycle();
        tests_run++;
        if (cout_s !== 16'd88 || ov_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL mac_signed: got Cout=%0d ov=%b expected 88 1", cout_s, ov_s);
        end
        cycle();
    endtask

    task automatic test_signed_sat();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 16'd0);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 16'd32760);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd10, 8'd10, 16'd0);
        cycle();
        idle();
        cycle();
        tests_run++;
        if (cout_s !== 16'd32767 || ovf_s !== 1'b1 || cout_w !== 16'h805C || ovf_w !== 1'b1) begin
            tests_failed++;
            $display("FAIL signed_ovf: got sat=%h/%b wrap=%h/%b expected 7fff/1 805c/1",
                     cout_s, ovf_s, cout_w, ovf_w);
        end
    endtask

    task automatic test_unsigned_sat();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 16'd0);
        cycle();
        cycle();
        tests_run++;
        if (cout_s !== 16'd65025 || ovf_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL unsigned_first: got Cout=%0d ovf=%b expected 65025 0", cout_s, ovf_s);
        end
        idle();
        cycle();
        tests_run++;
        if (cout_s !== 16'hFFFF || ovf_s !== 1'b1 || cout_w !== 16'hFC02 || ovf_w !== 1'b1) begin
            tests_failed++;
            $display("FAIL unsigned_ovf: got sat=%h/%b wrap=%h/%b expected ffff/1 fc02/1",
                     cout_s, ovf_s, cout_w, ovf_w);
        end
    endtask

    task automatic test_clr_priority();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'd7, 8'd7, 16'd1234);
        cycle();
        idle();
        cycle();
        tests_run++;
        if (cout_s !== 16'd0 || ovf_s !== 1'b0 || cout_w !== 16'd0 || ovf_w !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_priority: got Cout=%h/%h ovf=%b/%b expected 0 0", cout_s, cout_w, ovf_s, ovf_w);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2, 16'd0);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd3, 16'd0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 16'($urandom));
            en = 1'b0;
            cycle();
            tests_run++;
            if (ov_s !== 1'b0 || cout_s !== 16'd4 || aout_s !== 8'd3) begin
                tests_failed++;
                $display("FAIL stall_hold: got ov=%b Cout=%0d Aout=%0d expected 0 4 3", ov_s, cout_s, aout_s);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 8'd4, 16'd0);
        cycle();
        idle();
        cycle();
        tests_run++;
        if (cout_s !== 16'd29 || ov_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_final: got Cout=%0d ov=%b expected 29 1", cout_s, ov_s);
        end
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                  8'($urandom), 8'($urandom), 16'($urandom));
            en = 1'($urandom_range(0, 7) != 0);
            cycle();
        end
        idle();
        repeat (3) cycle();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom), 16'd0);
            cycle();
        end
        #2;
        rst = 1'b1;
        reset_model();
        #1;
        check_zero("reset_midstream");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            tests_run++;
            if (ov_s !== 1'b0 || ov_w !== 1'b0 || cout_s !== 16'd0) begin
                tests_failed++;
                $display("FAIL post_reset: got ov=%b/%b Cout=%h expected 0 0 0", ov_s, ov_w, cout_s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_mac();
        test_signed_sat();
        test_unsigned_sat();
        test_clr_priority();
        test_stall();
        test_back_to_back_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
